// File: rtl/vend_pkg.sv
// Shared types and product tables for the beverage vending controller.
// Price and recipe tables are indexed by the latched product number.
package vend_pkg;

  localparam int unsigned VEND_N_PRODUCTS = 4;
  localparam int unsigned VEND_N_INGR     = 5;
  localparam int unsigned VEND_CREDIT_W   = 6;
  localparam int unsigned PIDX_W          = $clog2(VEND_N_PRODUCTS);

  // Ingredient output positions
  localparam int unsigned ING_WATER  = 0;
  localparam int unsigned ING_COFFEE = 1;
  localparam int unsigned ING_MILK   = 2;
  localparam int unsigned ING_CHOC   = 3;
  localparam int unsigned ING_SUGAR  = 4;

  localparam logic [7:0] M_WATER  = 8'(1) << ING_WATER;
  localparam logic [7:0] M_COFFEE = 8'(1) << ING_COFFEE;
  localparam logic [7:0] M_MILK   = 8'(1) << ING_MILK;
  localparam logic [7:0] M_CHOC   = 8'(1) << ING_CHOC;
  localparam logic [7:0] M_SUGAR  = 8'(1) << ING_SUGAR;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PREP    = 2'd2,
    ST_DONE    = 2'd3
  } vend_state_t;

  // Entry 0 is the rightmost element
  localparam logic [VEND_N_PRODUCTS-1:0][7:0] PRICE = {8'd3, 8'd5, 8'd4, 8'd3};

  localparam logic [VEND_N_PRODUCTS-1:0][7:0] RECIPE = {
    M_SUGAR | M_COFFEE | M_WATER,
    M_CHOC  | M_MILK   | M_COFFEE | M_WATER,
    M_MILK  | M_COFFEE | M_WATER,
    M_COFFEE | M_WATER
  };

  // Price lookup; out-of-table products cost nothing
  function automatic logic [7:0] price_of(input int unsigned idx);
    logic [PIDX_W-1:0] i;
    i = PIDX_W'(idx);
    return (idx < VEND_N_PRODUCTS) ? PRICE[i] : 8'd0;
  endfunction

  // Recipe lookup; out-of-table products have an empty mask
  function automatic logic [7:0] recipe_of(input int unsigned idx);
    logic [PIDX_W-1:0] i;
    i = PIDX_W'(idx);
    return (idx < VEND_N_PRODUCTS) ? RECIPE[i] : 8'd0;
  endfunction

endpackage

// File: rtl/vend_step_timer.sv
// Loadable down-counter; expired_c is high for the single cycle in which a
// loaded count of N has run for N+1 cycles. Load takes priority over counting.
module vend_step_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired_c
);

  logic [CNT_W-1:0] count;
  logic             running;

  // Count down from the loaded value and stop after the terminal cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) running <= 1'b0;
      else             count   <= count - CNT_W'(1);
    end
  end

  assign expired_c = running && (count == '0);

endmodule

// File: rtl/beverage_vend_ctrl.sv
// Drink vending controller: credit collection, product select, price check,
// recipe-driven ingredient sequencing and change/refund hold.
// Optional macro VEND_TIMEOUT_EN: DONE also releases after TIMEOUT_CYCLES.
module beverage_vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned N_PRODUCTS     = VEND_N_PRODUCTS,
  parameter int unsigned N_INGR         = VEND_N_INGR,
  parameter int unsigned CREDIT_W       = VEND_CREDIT_W,
  parameter int unsigned STEP_CYCLES    = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sel_valid,
  input  logic [$clog2(N_PRODUCTS)-1:0] product_sel,
  input  logic                          coin_valid,
  input  logic                          coin_type,
  input  logic                          start,
  input  logic                          cancel,
  input  logic                          take_change,
  output logic [N_INGR-1:0]             ingr_active,
  output logic                          busy,
  output logic                          done,
  output logic [CREDIT_W-1:0]           credit,
  output logic [CREDIT_W-1:0]           price,
  output logic [CREDIT_W-1:0]           change_out,
  output logic                          insufficient,
  output logic                          coin_reject
);

  localparam int unsigned SEL_W     = $clog2(N_PRODUCTS);
  localparam int unsigned IDX_W     = $clog2(N_INGR + 1);
  localparam int unsigned MAX_DWELL = (STEP_CYCLES > TIMEOUT_CYCLES) ? STEP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_DWELL + 1);

  vend_state_t       state;
  logic [SEL_W-1:0]  sel_q;
  logic [IDX_W-1:0]  ingr_idx;

  logic [N_INGR-1:0] recipe_c;
  logic [IDX_W-1:0]  search_from_c;
  logic [IDX_W-1:0]  nxt_idx_c;
  logic              nxt_found_c;
  logic [CREDIT_W:0] coin_sum_c;
  logic              coin_ovf_c;
  logic              open_c;
  logic              cancel_ok_c;
  logic              start_ok_c;
  logic              step_next_c;
  logic              exit_done_c;
  logic              tmr_load_c;
  logic [CNT_W-1:0]  tmr_val_c;
  logic              tmr_exp_c;

  assign price    = CREDIT_W'(price_of(32'(sel_q)));
  assign recipe_c = N_INGR'(recipe_of(32'(sel_q)));

  // Find the next recipe ingredient: from index 0 when starting, past the current one in PREP
  always_comb begin
    search_from_c = (state == ST_PREP) ? (IDX_W'(ingr_idx) + IDX_W'(1)) : '0;
    nxt_found_c   = 1'b0;
    nxt_idx_c     = '0;
    for (int i = 0; i < int'(N_INGR); i++) begin
      if (!nxt_found_c && recipe_c[i] && (IDX_W'(i) >= search_from_c)) begin
        nxt_found_c = 1'b1;
        nxt_idx_c   = IDX_W'(i);
      end
    end
  end

  // Per-cycle decisions shared by the state register and the dwell/timeout timer
  always_comb begin
    open_c      = (state == ST_IDLE) || (state == ST_COLLECT);
    coin_sum_c  = {1'b0, credit} + (coin_type ? (CREDIT_W+1)'(5) : (CREDIT_W+1)'(1));
    coin_ovf_c  = coin_sum_c[CREDIT_W];
    cancel_ok_c = (state == ST_COLLECT) && cancel;
    start_ok_c  = open_c && start && !cancel_ok_c && (credit >= price);
    step_next_c = (state == ST_PREP) && tmr_exp_c;
    tmr_load_c  = (start_ok_c || step_next_c) && nxt_found_c;
    tmr_val_c   = CNT_W'(STEP_CYCLES - 1);
`ifdef VEND_TIMEOUT_EN
    exit_done_c = (state == ST_DONE) && (take_change || tmr_exp_c);
    // Restart the timer on every entry into DONE
    if (cancel_ok_c || ((start_ok_c || step_next_c) && !nxt_found_c)) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = CNT_W'(TIMEOUT_CYCLES - 1);
    end
`else
    exit_done_c = (state == ST_DONE) && take_change;
`endif
  end

  // Main controller state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      ingr_idx     <= '0;
      credit       <= '0;
      change_out   <= '0;
      ingr_active  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      insufficient <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      insufficient <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          // The product is frozen once preparation is accepted
          if (sel_valid && !start_ok_c) sel_q <= product_sel;
          if (cancel_ok_c) begin
            change_out  <= credit;
            credit      <= '0;
            coin_reject <= coin_valid;
            done        <= 1'b1;
            state       <= ST_DONE;
          end else if (start_ok_c) begin
            change_out  <= credit - price;
            credit      <= '0;
            coin_reject <= coin_valid;
            if (nxt_found_c) begin
              ingr_active <= N_INGR'(1) << nxt_idx_c;
              ingr_idx    <= nxt_idx_c;
              busy        <= 1'b1;
              state       <= ST_PREP;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else begin
            insufficient <= start;
            if (coin_valid) begin
              if (coin_ovf_c) begin
                coin_reject <= 1'b1;
              end else begin
                credit <= coin_sum_c[CREDIT_W-1:0];
                state  <= ST_COLLECT;
              end
            end
          end
        end
        ST_PREP: begin
          coin_reject <= coin_valid;
          if (step_next_c) begin
            if (nxt_found_c) begin
              ingr_active <= N_INGR'(1) << nxt_idx_c;
              ingr_idx    <= nxt_idx_c;
            end else begin
              ingr_active <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          coin_reject <= coin_valid;
          if (exit_done_c) begin
            done       <= 1'b0;
            change_out <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vend_step_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expired_c(tmr_exp_c)
  );

endmodule
